eth_frame_gen: RTL and testbench

//  Test-traffic source on the logic_clk side of the 10G MAC FIFO wrapper: builds Ethernet frames and drives them
//  as a 32-bit AXI-Stream master into the MAC tx_axis input. Each frame has DST/SRC MAC, EtherType, a 32-bit

---
 rtl/eth_frame_gen_pkg.sv | 40 ++++
 rtl/eth_frame_gen_word.sv | 47 ++++
 rtl/eth_frame_gen.sv | 190 +++++++++++++++++++
 tb/tb_eth_frame_gen.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_frame_gen_pkg.sv
// Shared definitions for the Ethernet test-frame generator: header layout,
// FSM state encoding, the last-word byte-enable table and the payload clamp.
package eth_frame_gen_pkg;

    // Default addressing and EtherType for generated frames
    localparam logic [47:0] DEF_DST_MAC   = 48'h02_00_00_00_00_02;
    localparam logic [47:0] DEF_SRC_MAC   = 48'h02_00_00_00_00_01;
    localparam logic [15:0] DEF_ETHERTYPE = 16'h88B5;

    // Header layout: DST(6) + SRC(6) + EtherType(2) = 14, then a 4-byte sequence number
    localparam int HDR_LEN     = 14;
    localparam int SEQ_END     = 18;
    localparam int MIN_PAYLOAD = 4;

    localparam int WORD_IDX_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Byte enables of the final word, indexed by frame length mod 4
    function automatic logic [3:0] last_keep(input logic [1:0] rem);
        case (rem)
            2'd0:    return 4'hF;
            2'd1:    return 4'h1;
            2'd2:    return 4'h3;
            default: return 4'h7;
        endcase
    endfunction

    // The sequence number needs at least 4 payload bytes; the MAC limits the top end
    function automatic logic [10:0] clamp_len(input logic [10:0] len, input logic [10:0] max_len);
        if (len < 11'(MIN_PAYLOAD)) return 11'(MIN_PAYLOAD);
        else if (len > max_len)     return max_len;
        else                        return len;
    endfunction

endpackage

// File: rtl/eth_frame_gen_word.sv
// Combinational byte-lane builder: given a word index, the sequence number
// and the clamped payload length, produce one 32-bit AXIS word, its byte
// enables and whether it is the last word of the frame.
module eth_frame_gen_word
    import eth_frame_gen_pkg::*;
#(
    parameter logic [47:0] DST_MAC   = DEF_DST_MAC,
    parameter logic [47:0] SRC_MAC   = DEF_SRC_MAC,
    parameter logic [15:0] ETHERTYPE = DEF_ETHERTYPE
) (
    input  logic [WORD_IDX_W-1:0] word_idx,
    input  logic [31:0]           seq,
    input  logic [10:0]           payload_len,
    output logic [31:0]           data,
    output logic [3:0]            keep,
    output logic                  last
);

    logic [11:0] frame_len;
    logic [11:0] num_words;

    // Byte b of the frame, for b below the frame length
    function automatic logic [7:0] byte_at(input int b, input logic [31:0] s);
        if (b < 6)              return DST_MAC[8*(5-b) +: 8];
        else if (b < 12)        return SRC_MAC[8*(11-b) +: 8];
        else if (b == 12)       return ETHERTYPE[15:8];
        else if (b == 13)       return ETHERTYPE[7:0];
        else if (b < SEQ_END)   return s[8*(SEQ_END-1-b) +: 8];
        else                    return 8'(b - HDR_LEN);
    endfunction

    // Assemble lanes 0..3 from bytes 4w..4w+3; lanes past the frame end read as zero
    always_comb begin
        // NOTE: every output gets a value before any branch, so no path leaves one
        // unassigned and no latch is inferred.
        data      = '0;
        frame_len = 12'(HDR_LEN) + 12'(payload_len);
        num_words = (frame_len + 12'd3) >> 2;
        last      = ({2'b00, word_idx} == num_words - 12'd1);
        keep      = last ? last_keep(frame_len[1:0]) : 4'hF;
        for (int k = 0; k < 4; k++) begin
            if (4 * int'(word_idx) + k < int'(frame_len))
                data[8*k +: 8] = byte_at(4 * int'(word_idx) + k, seq);
        end
    end

endmodule

// File: rtl/eth_frame_gen.sv
// Ethernet test-traffic source: emits runs of frames (DST/SRC/EtherType,
// 32-bit sequence number, incrementing byte pattern) as a 32-bit AXI-Stream
// master. The MAC downstream appends padding and FCS.
module eth_frame_gen
    import eth_frame_gen_pkg::*;
#(
    parameter logic [47:0] DST_MAC     = DEF_DST_MAC,
    parameter logic [47:0] SRC_MAC     = DEF_SRC_MAC,
    parameter logic [15:0] ETHERTYPE   = DEF_ETHERTYPE,
    parameter int          MAX_PAYLOAD = 1500
) (
    input  logic        logic_clk,
    input  logic        logic_rst,
    input  logic        start,
    input  logic        stop,
    input  logic [10:0] payload_len,
    input  logic [15:0] frame_count,
    input  logic [15:0] gap_cycles,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        busy,
    output logic [31:0] frames_sent
);

    state_t                state;
    state_t                state_next;

    // Run parameters captured at start
    logic [10:0]           len_q;
    logic [15:0]           count_q;
    logic [15:0]           gap_q;

    logic [15:0]           gap_cnt;
    logic [15:0]           issued;
    logic [31:0]           seq;
    logic [WORD_IDX_W-1:0] word_idx;
    logic                  stop_pend;

    logic [10:0]           len_clamped;
    logic                  hs;
    logic                  hs_last;
    logic                  stop_now;
    logic                  run_done;

    // Builder input selection and load strobe for the output word registers
    logic                  load;
    logic [WORD_IDX_W-1:0] load_idx;
    logic [31:0]           load_seq;
    logic [10:0]           load_len;

    logic [31:0]           w_data;
    logic [3:0]            w_keep;
    logic                  w_last;

    assign len_clamped  = clamp_len(payload_len, 11'(MAX_PAYLOAD));
    assign hs           = m_axis_tvalid & m_axis_tready;
    assign hs_last      = hs & m_axis_tlast;
    assign stop_now     = stop | stop_pend;
    assign run_done     = (count_q != 16'd0) && (issued + 16'd1 == count_q);
    assign m_axis_tuser = 1'b0;

    eth_frame_gen_word #(
        .DST_MAC   (DST_MAC),
        .SRC_MAC   (SRC_MAC),
        .ETHERTYPE (ETHERTYPE)
    ) u_word (
        .word_idx    (load_idx),
        .seq         (load_seq),
        .payload_len (load_len),
        .data        (w_data),
        .keep        (w_keep),
        .last        (w_last)
    );

    // FSM state register
    always_ff @(posedge logic_clk) begin
        // NOTE: clocked state uses non-blocking assignment so every register
        // samples the pre-edge values regardless of statement order.
        if (logic_rst) state <= ST_IDLE;
        else           state <= state_next;
    end

    // Next-state: frames are never truncated; stop and run completion act at frame boundaries or in the gap
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_SEND;
            ST_SEND: begin
                if (hs_last) begin
                    if (run_done || stop_now)  state_next = ST_IDLE;
                    else if (gap_q != 16'd0)   state_next = ST_GAP;
                    else                       state_next = ST_SEND;
                end
            end
            ST_GAP: begin
                if (stop_now)                 state_next = ST_IDLE;
                else if (gap_cnt == 16'd1)    state_next = ST_SEND;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output control: decide which word (index, seq, length) to load into the AXIS registers
    always_comb begin
        load     = 1'b0;
        load_idx = word_idx + 10'd1;
        load_seq = seq;
        load_len = len_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    load_idx = '0;
                    load_seq = '0;
                    load_len = len_clamped;
                end
            end
            ST_SEND: begin
                if (hs && !m_axis_tlast) begin
                    load = 1'b1;
                end else if (hs_last && state_next == ST_SEND) begin
                    load     = 1'b1;
                    load_idx = '0;
                    load_seq = seq + 32'd1;
                end
            end
            ST_GAP: begin
                if (state_next == ST_SEND) begin
                    load     = 1'b1;
                    load_idx = '0;
                end
            end
            default: load = 1'b0;
        endcase
    end

    // Datapath registers: AXIS outputs, run parameters, counters and status
    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            busy          <= 1'b0;
            frames_sent   <= '0;
            seq           <= '0;
            issued        <= '0;
            word_idx      <= '0;
            gap_cnt       <= '0;
            stop_pend     <= 1'b0;
            len_q         <= 11'(MIN_PAYLOAD);
            count_q       <= '0;
            gap_q         <= '0;
        end else begin
            m_axis_tvalid <= (state_next == ST_SEND);
            busy          <= (state_next != ST_IDLE);

            if (load) begin
                m_axis_tdata <= w_data;
                m_axis_tkeep <= w_keep;
                m_axis_tlast <= w_last;
                word_idx     <= load_idx;
            end

            if (state == ST_IDLE && start) begin
                len_q   <= len_clamped;
                count_q <= frame_count;
                gap_q   <= gap_cycles;
                seq     <= '0;
                issued  <= '0;
            end else if (hs_last) begin
                frames_sent <= frames_sent + 32'd1;
                seq         <= seq + 32'd1;
                issued      <= issued + 16'd1;
            end

            // Stop is remembered only while a run is active and cleared on return to idle
            if (state_next == ST_IDLE)          stop_pend <= 1'b0;
            else if (state != ST_IDLE && stop)  stop_pend <= 1'b1;

            if (hs_last && state_next == ST_GAP) gap_cnt <= gap_q;
            else if (state == ST_GAP)            gap_cnt <= gap_cnt - 16'd1;
        end
    end

endmodule

// File: tb/tb_eth_frame_gen.sv
// Directed bench for eth_frame_gen: header/pattern content, byte enables,
// backpressure, inter-frame gaps, stop, clamping and reset behaviour.
module tb_eth_frame_gen;

    logic        logic_clk = 1'b0;
    logic        logic_rst;
    logic        start;
    logic        stop;
    logic [10:0] payload_len;
    logic [15:0] frame_count;
    logic [15:0] gap_cycles;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        busy;
    logic [31:0] frames_sent;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] cap_data[$];
    logic [3:0]  cap_keep[$];
    logic        cap_last[$];
    int          gaps[$];
    int          frames_got;

    eth_frame_gen dut (
        .logic_clk     (logic_clk),
        .logic_rst     (logic_rst),
        .start         (start),
        .stop          (stop),
        .payload_len   (payload_len),
        .frame_count   (frame_count),
        .gap_cycles    (gap_cycles),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .busy          (busy),
        .frames_sent   (frames_sent)
    );

    always #5 logic_clk = ~logic_clk;

    // Reference frame model
    function automatic logic [7:0] exp_byte(input int b, input logic [31:0] s);
        logic [47:0] dst = 48'h02_00_00_00_00_02;
        logic [47:0] src = 48'h02_00_00_00_00_01;
        if (b < 6)        return dst[8*(5-b) +: 8];
        else if (b < 12)  return src[8*(11-b) +: 8];
        else if (b == 12) return 8'h88;
        else if (b == 13) return 8'hB5;
        else if (b < 18)  return s[8*(17-b) +: 8];
        else              return 8'(b - 14);
    endfunction

    function automatic int num_words(input int len);
        return (14 + len + 3) / 4;
    endfunction

    function automatic logic [31:0] exp_word(input int idx, input logic [31:0] s, input int len);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++)
            if (4 * idx + k < 14 + len) w[8*k +: 8] = exp_byte(4 * idx + k, s);
        return w;
    endfunction

    function automatic logic [3:0] exp_keep(input int idx, input int len);
        if (idx != num_words(len) - 1) return 4'hF;
        case ((14 + len) % 4)
            0:       return 4'hF;
            1:       return 4'h1;
            2:       return 4'h3;
            default: return 4'h7;
        endcase
    endfunction

    function automatic logic [31:0] keep_mask(input logic [3:0] k);
        logic [31:0] m = '0;
        for (int i = 0; i < 4; i++) if (k[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // Stimulus helpers; all return at a falling edge
    task automatic do_reset();
        @(negedge logic_clk);
        logic_rst     = 1'b1;
        start         = 1'b0;
        stop          = 1'b0;
        m_axis_tready = 1'b1;
        repeat (2) @(negedge logic_clk);
        logic_rst = 1'b0;
    endtask

    task automatic pulse_start(input int len, input int count, input int gap);
        payload_len = 11'(len);
        frame_count = 16'(count);
        gap_cycles  = 16'(gap);
        start       = 1'b1;
        @(negedge logic_clk);
        start = 1'b0;
    endtask

    // Collect handshaken words and inter-frame idle lengths; also checks hold-while-stalled
    task automatic capture(input int nframes, input int ready_pct, input int budget, output bit timed_out);
        int          idle = 0;
        bit          after_last = 1'b0;
        bit          prev_stall = 1'b0;
        logic [31:0] pd = '0;
        logic [3:0]  pk = '0;
        logic        pl = 1'b0;
        cap_data.delete(); cap_keep.delete(); cap_last.delete(); gaps.delete();
        frames_got = 0;
        for (int cyc = 0; cyc < budget && frames_got < nframes; cyc++) begin
            m_axis_tready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
            if (prev_stall) begin
                vectors++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd || m_axis_tkeep !== pk || m_axis_tlast !== pl) begin
                    miscompares++;
                    $display("FAIL hold_stable: got v=%b d=%h k=%h l=%b, required v=1 d=%h k=%h l=%b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, pd, pk, pl);
                end
            end
            if (m_axis_tvalid === 1'b1) begin
                if (after_last) begin gaps.push_back(idle); after_last = 1'b0; end
            end else if (after_last) begin
                idle++;
            end
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                cap_data.push_back(m_axis_tdata);
                cap_keep.push_back(m_axis_tkeep);
                cap_last.push_back(m_axis_tlast);
                if (m_axis_tlast === 1'b1) begin frames_got++; after_last = 1'b1; idle = 0; end
            end
            prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
            pd = m_axis_tdata; pk = m_axis_tkeep; pl = m_axis_tlast;
            @(negedge logic_clk);
        end
        m_axis_tready = 1'b1;
        timed_out = (frames_got < nframes);
    endtask

    task automatic test_reset();
        logic_rst = 1'b1; start = 1'b0; stop = 1'b0; m_axis_tready = 1'b1;
        payload_len = 11'd46; frame_count = 16'd1; gap_cycles = 16'd0;
        repeat (3) @(negedge logic_clk);
        logic_rst = 1'b0;
        vectors++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tuser !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got v=%b l=%b u=%b busy=%b, required all 0", m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy);
        end
        vectors++;
        if (m_axis_tdata !== 32'h0 || m_axis_tkeep !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_data: got d=%h k=%h, required 0/0", m_axis_tdata, m_axis_tkeep);
        end
        vectors++;
        if (frames_sent !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_frames_sent: got %0d, required 0", frames_sent);
        end
    endtask

    task automatic test_single();
        bit to;
        do_reset();
        pulse_start(46, 1, 0);
        vectors++;
        if (m_axis_tvalid !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_latency: got v=%b busy=%b, required 1/1", m_axis_tvalid, busy);
        end
        capture(1, 100, 100, to);
        vectors++;
        if (to || cap_data.size() != 15) begin
            miscompares++;
            $display("FAIL single_words: got %0d words (timeout=%0b), required 15", cap_data.size(), to);
        end
        if (cap_data.size() >= 2) begin
            vectors++;
            if (cap_data[0] !== 32'h00000002) begin
                miscompares++;
                $display("FAIL single_word0: got %h, required 00000002", cap_data[0]);
            end
            vectors++;
            if (cap_data[1] !== 32'h00020200) begin
                miscompares++;
                $display("FAIL single_word1: got %h, required 00020200", cap_data[1]);
            end
        end
        for (int i = 0; i < cap_data.size(); i++) begin
            vectors++;
            if ((cap_data[i] & keep_mask(cap_keep[i])) !== exp_word(i, 0, 46) ||
                cap_keep[i] !== exp_keep(i, 46) || cap_last[i] !== (i == 14)) begin
                miscompares++;
                $display("FAIL single_w%0d: got d=%h k=%h l=%b, required d=%h k=%h l=%b", i,
                         cap_data[i], cap_keep[i], cap_last[i], exp_word(i, 0, 46), exp_keep(i, 46), i == 14);
            end
        end
        repeat (2) @(negedge logic_clk);
        vectors++;
        if (frames_sent !== 32'd1 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done: got sent=%0d busy=%b v=%b, required 1/0/0", frames_sent, busy, m_axis_tvalid);
        end
    endtask

    task automatic test_len47();
        bit to;
        do_reset();
        pulse_start(47, 1, 0);
        capture(1, 100, 100, to);
        vectors++;
        if (to || cap_data.size() != 16) begin
            miscompares++;
            $display("FAIL len47_words: got %0d words, required 16", cap_data.size());
        end else begin
            vectors++;
            if (cap_keep[15] !== 4'h1 || cap_data[15][7:0] !== 8'h2E || cap_last[15] !== 1'b1) begin
                miscompares++;
                $display("FAIL len47_last: got k=%h b0=%h l=%b, required 1/2e/1", cap_keep[15], cap_data[15][7:0], cap_last[15]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        do_reset();
        pulse_start(100, 1, 0);
        capture(1, 50, 2000, to);
        vectors++;
        if (to || cap_data.size() != num_words(100)) begin
            miscompares++;
            $display("FAIL bp_words: got %0d, required %0d", cap_data.size(), num_words(100));
        end
        for (int i = 0; i < cap_data.size(); i++) begin
            vectors++;
            if ((cap_data[i] & keep_mask(cap_keep[i])) !== exp_word(i, 0, 100) ||
                cap_keep[i] !== exp_keep(i, 100) || cap_last[i] !== (i == num_words(100) - 1)) begin
                miscompares++;
                $display("FAIL bp_w%0d: got d=%h k=%h l=%b, required d=%h k=%h", i,
                         cap_data[i], cap_keep[i], cap_last[i], exp_word(i, 0, 100), exp_keep(i, 100));
            end
        end
    endtask

    task automatic test_gap();
        bit to;
        int nw = num_words(20);
        do_reset();
        pulse_start(20, 3, 5);
        capture(3, 100, 300, to);
        vectors++;
        if (to || cap_data.size() != 3 * nw) begin
            miscompares++;
            $display("FAIL gap_words: got %0d, required %0d", cap_data.size(), 3 * nw);
        end
        vectors++;
        if (gaps.size() != 2) begin
            miscompares++;
            $display("FAIL gap_count: got %0d gaps, required 2", gaps.size());
        end
        for (int g = 0; g < gaps.size(); g++) begin
            vectors++;
            if (gaps[g] != 5) begin
                miscompares++;
                $display("FAIL gap_len%0d: got %0d idle cycles, required 5", g, gaps[g]);
            end
        end
        for (int i = 0; i < cap_data.size(); i++) begin
            vectors++;
            if ((cap_data[i] & keep_mask(cap_keep[i])) !== exp_word(i % nw, 32'(i / nw), 20) ||
                cap_last[i] !== (i % nw == nw - 1)) begin
                miscompares++;
                $display("FAIL gap_w%0d: got d=%h l=%b, required d=%h", i, cap_data[i], cap_last[i],
                         exp_word(i % nw, 32'(i / nw), 20));
            end
        end
        vectors++;
        if (frames_sent !== 32'd3 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_done: got sent=%0d busy=%b, required 3/0", frames_sent, busy);
        end
    endtask

    task automatic test_stop();
        int nw = num_words(30);
        int f = 0;
        int w = 0;
        int late = 0;
        do_reset();
        pulse_start(30, 0, 0);
        cap_data.delete(); cap_keep.delete(); cap_last.delete();
        for (int cyc = 0; cyc < 200 && f < 4; cyc++) begin
            stop  = (m_axis_tvalid === 1'b1 && f == 3 && w == 7);
            start = 1'b0;
            if (m_axis_tvalid === 1'b1 && f == 2 && w == 2) begin
                start = 1'b1; payload_len = 11'd4; frame_count = 16'd1;
            end
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                cap_data.push_back(m_axis_tdata);
                cap_last.push_back(m_axis_tlast);
                w++;
                if (m_axis_tlast === 1'b1) begin f++; w = 0; end
            end
            @(negedge logic_clk);
        end
        stop = 1'b0; start = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (m_axis_tvalid !== 1'b0) late++;
            @(negedge logic_clk);
        end
        vectors++;
        if (cap_data.size() != 4 * nw || late != 0) begin
            miscompares++;
            $display("FAIL stop_words: got %0d words, %0d late valid, required %0d/0", cap_data.size(), late, 4 * nw);
        end
        for (int i = 0; i < cap_data.size(); i++) begin
            vectors++;
            if (cap_data[i] !== exp_word(i % nw, 32'(i / nw), 30) || cap_last[i] !== (i % nw == nw - 1)) begin
                miscompares++;
                $display("FAIL stop_w%0d: got d=%h l=%b, required d=%h", i, cap_data[i], cap_last[i],
                         exp_word(i % nw, 32'(i / nw), 30));
            end
        end
        vectors++;
        if (frames_sent !== 32'd4 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_done: got sent=%0d busy=%b, required 4/0", frames_sent, busy);
        end
    endtask

    task automatic test_clamp();
        bit to;
        do_reset();
        pulse_start(2, 1, 0);
        capture(1, 100, 100, to);
        vectors++;
        if (to || cap_data.size() != 5 || cap_keep[cap_keep.size()-1] !== 4'h3) begin
            miscompares++;
            $display("FAIL clamp_low: got %0d words, required 5 with last keep 3", cap_data.size());
        end
        for (int i = 0; i < cap_data.size(); i++) begin
            vectors++;
            if ((cap_data[i] & keep_mask(cap_keep[i])) !== exp_word(i, 0, 4)) begin
                miscompares++;
                $display("FAIL clamp_low_w%0d: got %h, required %h", i, cap_data[i], exp_word(i, 0, 4));
            end
        end
        do_reset();
        pulse_start(2000, 1, 0);
        capture(1, 100, 500, to);
        vectors++;
        if (to || cap_data.size() != 379 || cap_keep[cap_keep.size()-1] !== 4'h3 || cap_last[cap_last.size()-1] !== 1'b1) begin
            miscompares++;
            $display("FAIL clamp_high: got %0d words, required 379 with last keep 3", cap_data.size());
        end
        for (int i = 0; i < cap_data.size(); i++) begin
            vectors++;
            if ((cap_data[i] & keep_mask(cap_keep[i])) !== exp_word(i, 0, 1500) || cap_keep[i] !== exp_keep(i, 1500)) begin
                miscompares++;
                $display("FAIL clamp_high_w%0d: got d=%h k=%h, required d=%h k=%h", i,
                         cap_data[i], cap_keep[i], exp_word(i, 0, 1500), exp_keep(i, 1500));
            end
        end
    endtask

    task automatic test_reset_mid();
        int hs_cnt = 0;
        int late = 0;
        do_reset();
        pulse_start(100, 1, 0);
        for (int cyc = 0; cyc < 50 && hs_cnt < 10; cyc++) begin
            if (m_axis_tvalid === 1'b1) hs_cnt++;
            @(negedge logic_clk);
        end
        logic_rst = 1'b1;
        @(negedge logic_clk);
        logic_rst = 1'b0;
        vectors++;
        if (hs_cnt != 10 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'h0 || m_axis_tkeep !== 4'h0 ||
            m_axis_tlast !== 1'b0 || busy !== 1'b0 || frames_sent !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got words=%0d v=%b d=%h k=%h l=%b busy=%b sent=%0d, required 10 and reset values",
                     hs_cnt, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, busy, frames_sent);
        end
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (m_axis_tvalid !== 1'b0) late++;
            @(negedge logic_clk);
        end
        vectors++;
        if (late != 0) begin
            miscompares++;
            $display("FAIL reset_mid_quiet: got %0d valid cycles after reset, required 0", late);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_len47();
        test_backpressure();
        test_gap();
        test_stop();
        test_clamp();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
